// File: rtl/hazard_detection_mc_if.sv
// Bundle of the hazard unit's pipeline-side signals: the ID/EX operand view and memory/flush
// controls in, the stall and bubble controls plus the performance counters out.
interface hazard_detection_mc_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] ID_rs1_i;
  logic [ADDR_W-1:0] ID_rs2_i;
  logic              ID_rs1_use_i;
  logic              ID_rs2_use_i;
  logic [ADDR_W-1:0] EX_rd_i;
  logic              EX_MemRead_i;
  logic              mem_stall_i;
  logic              flush_i;
  logic              PCWrite_o;
  logic              Stall_o;
  logic              NoOp_o;
  logic              MemStall_o;
  logic [CNT_W-1:0]  lu_cnt_o;
  logic [CNT_W-1:0]  mem_cnt_o;

  modport slave (
    input  ID_rs1_i, ID_rs2_i, ID_rs1_use_i, ID_rs2_use_i,
    input  EX_rd_i, EX_MemRead_i, mem_stall_i, flush_i,
    output PCWrite_o, Stall_o, NoOp_o, MemStall_o, lu_cnt_o, mem_cnt_o
  );

  modport master (
    output ID_rs1_i, ID_rs2_i, ID_rs1_use_i, ID_rs2_use_i,
    output EX_rd_i, EX_MemRead_i, mem_stall_i, flush_i,
    input  PCWrite_o, Stall_o, NoOp_o, MemStall_o, lu_cnt_o, mem_cnt_o
  );
endinterface

// File: rtl/hazard_detection_mc.sv
// Load-use hazard unit with a multi-cycle bubble sequence, memory-stall freeze and flush override.
// Optional saturating stall counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_detection_mc #(
  parameter int ADDR_W = 5,
  parameter int LU_CYC = 1,
  parameter int CNT_W  = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  hazard_detection_mc_if.slave bus
);

  typedef enum logic {IDLE, LU_STALL} state_t;

  localparam logic [2:0] BUB_INIT = 3'(LU_CYC - 1);

  state_t            state, next_state;
  logic [2:0]        bub_cnt, next_bub_cnt;
  logic [ADDR_W-1:0] ex_rd;
  logic              hazard;
  logic              pc_write, stall, noop, mem_freeze;

  assign ex_rd  = bus.EX_rd_i;
  assign hazard = bus.EX_MemRead_i && (ex_rd != '0) &&
                  ((bus.ID_rs1_use_i && (bus.ID_rs1_i == ex_rd)) ||
                   (bus.ID_rs2_use_i && (bus.ID_rs2_i == ex_rd)));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      bub_cnt <= '0;
    end else begin
      state   <= next_state;
      bub_cnt <= next_bub_cnt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    next_state   = state;
    next_bub_cnt = bub_cnt;
    pc_write     = 1'b1;
    stall        = 1'b0;
    noop         = 1'b0;
    mem_freeze   = 1'b0;
    // Outputs are gated by reset so the pipeline sees run values while reset is held.
    if (!rst_i) begin
      if (bus.mem_stall_i) begin
        mem_freeze = 1'b1;
        pc_write   = 1'b0;
        stall      = 1'b1;
      end else if (bus.flush_i) begin
        next_state   = IDLE;
        next_bub_cnt = '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (hazard) begin
              pc_write = 1'b0;
              stall    = 1'b1;
              noop     = 1'b1;
              if (LU_CYC > 1) begin
                next_state   = LU_STALL;
                next_bub_cnt = BUB_INIT;
              end
            end
          end
          LU_STALL: begin
            pc_write = 1'b0;
            stall    = 1'b1;
            noop     = 1'b1;
            if (bub_cnt == 3'd1) begin
              next_state   = IDLE;
              next_bub_cnt = '0;
            end else begin
              next_bub_cnt = bub_cnt - 3'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.PCWrite_o  = pc_write;
  assign bus.Stall_o    = stall;
  assign bus.NoOp_o     = noop;
  assign bus.MemStall_o = mem_freeze;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt, mem_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lu_cnt  <= '0;
      mem_cnt <= '0;
    end else begin
      if (noop && (lu_cnt != '1))
        lu_cnt <= lu_cnt + CNT_W'(1);
      if (mem_freeze && (mem_cnt != '1))
        mem_cnt <= mem_cnt + CNT_W'(1);
    end
  end

  assign bus.lu_cnt_o  = lu_cnt;
  assign bus.mem_cnt_o = mem_cnt;
`else
  assign bus.lu_cnt_o  = {CNT_W{1'b0}};
  assign bus.mem_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_detection_mc.sv
// Directed bench driving LU_CYC=1 and LU_CYC=3 (CNT_W=2) instances with identical stimulus;
// expected control codes are queued per step and compared at the following falling edge.
module tb_hazard_detection_mc;

  // Control code order: {PCWrite_o, Stall_o, NoOp_o, MemStall_o}
  localparam logic [3:0] RUN = 4'b1000;
  localparam logic [3:0] BUB = 4'b0110;
  localparam logic [3:0] MEM = 4'b0101;

  typedef struct {
    string      tag;
    logic [3:0] e1;
    logic [3:0] e3;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int unsigned lu1 = 0, mem1 = 0, lu3 = 0, mem3 = 0;

  hazard_detection_mc_if #(.ADDR_W(5), .CNT_W(16)) if1 ();
  hazard_detection_mc_if #(.ADDR_W(5), .CNT_W(2))  if3 ();

  hazard_detection_mc #(.ADDR_W(5), .LU_CYC(1), .CNT_W(16)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1)
  );

  hazard_detection_mc #(.ADDR_W(5), .LU_CYC(3), .CNT_W(2)) dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if3)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic ld,
                       input logic ms, input logic fl);
    if1.ID_rs1_i = rs1; if1.ID_rs1_use_i = u1; if1.ID_rs2_i = rs2; if1.ID_rs2_use_i = u2;
    if1.EX_rd_i = rd; if1.EX_MemRead_i = ld; if1.mem_stall_i = ms; if1.flush_i = fl;
    if3.ID_rs1_i = rs1; if3.ID_rs1_use_i = u1; if3.ID_rs2_i = rs2; if3.ID_rs2_use_i = u2;
    if3.EX_rd_i = rd; if3.EX_MemRead_i = ld; if3.mem_stall_i = ms; if3.flush_i = fl;
  endtask

  task automatic step(input string tag, input logic [3:0] e1, input logic [3:0] e3);
    exp_t item;
    exp_t got;
    logic [15:0] x_lu1, x_mem1, x_lu3, x_mem3;
    item.tag = tag;
    item.e1  = e1;
    item.e3  = e3;
    sb.push_back(item);
    @(negedge clk);
    got = sb.pop_front();
    if (rst) begin
      lu1 = 0; mem1 = 0; lu3 = 0; mem3 = 0;
    end
`ifdef HAZARD_PERF_CNT_EN
    x_lu1 = 16'(lu1); x_mem1 = 16'(mem1); x_lu3 = 16'(lu3); x_mem3 = 16'(mem3);
`else
    x_lu1 = '0; x_mem1 = '0; x_lu3 = '0; x_mem3 = '0;
`endif
    check({got.tag, "/ctl_lc1"},
          16'({if1.PCWrite_o, if1.Stall_o, if1.NoOp_o, if1.MemStall_o}), 16'(got.e1));
    check({got.tag, "/ctl_lc3"},
          16'({if3.PCWrite_o, if3.Stall_o, if3.NoOp_o, if3.MemStall_o}), 16'(got.e3));
    check({got.tag, "/lu_cnt_lc1"},  if1.lu_cnt_o,       x_lu1);
    check({got.tag, "/mem_cnt_lc1"}, if1.mem_cnt_o,      x_mem1);
    check({got.tag, "/lu_cnt_lc3"},  16'(if3.lu_cnt_o),  x_lu3);
    check({got.tag, "/mem_cnt_lc3"}, 16'(if3.mem_cnt_o), x_mem3);
    if (!rst) begin
      if (got.e1[1]) lu1  = sat_inc(lu1, 65535);
      if (got.e1[0]) mem1 = sat_inc(mem1, 65535);
      if (got.e3[1]) lu3  = sat_inc(lu3, 3);
      if (got.e3[0]) mem3 = sat_inc(mem3, 3);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset held with a live hazard on the inputs
    drive(0, 0, 5, 1, 5, 1, 0, 0);  step("rst_hold", RUN, RUN);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("idle0", RUN, RUN);

    // rd=5 load, rs2=5 used; hazard dropped after one cycle
    drive(0, 0, 5, 1, 5, 1, 0, 0);  step("lu_a0", BUB, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("lu_a1", RUN, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("lu_a2", RUN, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("lu_a3", RUN, RUN);

    // Register 0 and unused operand never stall
    drive(0, 1, 0, 0, 0, 1, 0, 0);  step("rd_zero", RUN, RUN);
    drive(7, 0, 7, 0, 7, 1, 0, 0);  step("unused_op", RUN, RUN);

    // Memory stall for 4 cycles during the 2nd bubble
    drive(3, 1, 0, 0, 3, 1, 0, 0);  step("ms_b0", BUB, BUB);
    drive(0, 0, 0, 0, 0, 0, 1, 0);  step("ms_f0", MEM, MEM);
    drive(0, 0, 0, 0, 0, 0, 1, 0);  step("ms_f1", MEM, MEM);
    drive(0, 0, 0, 0, 0, 0, 1, 0);  step("ms_f2", MEM, MEM);
    drive(0, 0, 0, 0, 0, 0, 1, 0);  step("ms_f3", MEM, MEM);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("ms_b1", RUN, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("ms_b2", RUN, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("ms_done", RUN, RUN);

    // Flush on a hazard cycle, then flush in the middle of the bubble run
    drive(9, 1, 0, 0, 9, 1, 0, 1);  step("fl_haz", RUN, RUN);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("fl_idle", RUN, RUN);
    drive(9, 1, 0, 0, 9, 1, 0, 0);  step("fl_b0", BUB, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 1);  step("fl_mid", RUN, RUN);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("fl_after", RUN, RUN);

    // Memory stall outranks flush and hazard
    drive(9, 1, 0, 0, 9, 1, 1, 1);  step("prio_ms", MEM, MEM);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("prio_after", RUN, RUN);

    // Fresh hazard on the IDLE cycle right after a bubble run
    drive(4, 1, 0, 0, 4, 1, 0, 0);  step("re_a0", BUB, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("re_a1", RUN, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("re_a2", RUN, BUB);
    drive(0, 0, 4, 1, 4, 1, 0, 0);  step("re_b0", BUB, BUB);
    drive(0, 0, 4, 1, 4, 1, 0, 0);  step("re_b1", BUB, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("re_b2", RUN, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("re_done", RUN, RUN);

    // Reset pulse in the middle of a bubble run
    drive(6, 1, 0, 0, 6, 1, 0, 0);  step("rst_b0", BUB, BUB);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("rst_mid", RUN, RUN);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("rst_after", RUN, RUN);
    drive(0, 0, 6, 1, 6, 1, 0, 0);  step("post_rst_haz", BUB, BUB);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  step("post_rst_b1", RUN, BUB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_detection_mc.md
HAZARD_DETECTION_MC -- requirements
Module: hazard_detection_mc

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter LU_CYC, default 1, load-use bubbles per hazard; legal range 1..4.
REQ-003 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have ports ID_rs1_i, ID_rs2_i  input  ADDR_W  source registers of the instruction in ID.
REQ-007 SHALL have ports ID_rs1_use_i, ID_rs2_use_i  input  1  the ID instruction actually reads rs1 / rs2.
REQ-008 SHALL have port EX_rd_i  input  ADDR_W  destination register of the instruction in EX.
REQ-009 SHALL have port EX_MemRead_i  input  1  the EX instruction is a load.
REQ-010 SHALL have port mem_stall_i  input  1  data memory busy; the whole pipeline must freeze.
REQ-011 SHALL have port flush_i  input  1  the ID instruction is being flushed (taken branch).
REQ-012 SHALL have port PCWrite_o  output  1  PC may update.
REQ-013 SHALL have port Stall_o  output  1  hold the IF/ID register.
REQ-014 SHALL have port NoOp_o  output  1  insert a bubble into ID/EX.
REQ-015 SHALL have port MemStall_o  output  1  freeze all pipeline registers.
REQ-016 SHALL have ports lu_cnt_o, mem_cnt_o  output  CNT_W  load-use and memory stall-cycle counters.

Function
REQ-017 SHALL define a hazard as EX_MemRead_i && EX_rd_i!=0 && ((ID_rs1_use_i && ID_rs1_i==EX_rd_i) || (ID_rs2_use_i && ID_rs2_i==EX_rd_i)).
REQ-018 SHALL never flag a hazard on register 0 or on an unused source operand.
REQ-019 SHALL implement FSM states IDLE and LU_STALL with a down-counter bub_cnt of width 3.
REQ-020 SHALL, in IDLE with a hazard, drive PCWrite_o=0, Stall_o=1, NoOp_o=1 in the same cycle (combinational, zero latency).
REQ-021 SHALL, on that cycle when LU_CYC>1, go to LU_STALL with bub_cnt=LU_CYC-1; when LU_CYC==1, stay in IDLE.
REQ-022 SHALL, in LU_STALL, drive PCWrite_o=0, Stall_o=1, NoOp_o=1 regardless of the hazard term, and decrement bub_cnt.
REQ-023 SHALL go from LU_STALL to IDLE on the edge where bub_cnt==1, so each hazard produces exactly LU_CYC bubble cycles.
REQ-024 SHALL, while mem_stall_i=1, drive MemStall_o=1, PCWrite_o=0, Stall_o=1 and NoOp_o=0, and hold state and bub_cnt unchanged.
REQ-025 SHALL give mem_stall_i priority over flush_i, and flush_i priority over hazard/LU_STALL.
REQ-026 SHALL, with flush_i=1 and mem_stall_i=0, drive PCWrite_o=1, Stall_o=0, NoOp_o=0, force the state to IDLE and clear bub_cnt.
REQ-027 SHALL otherwise drive PCWrite_o=1, Stall_o=0, NoOp_o=0, MemStall_o=0.
REQ-028 SHALL make a new hazard detected on the IDLE cycle right after LU_STALL start a fresh LU_CYC sequence.

Reset
REQ-029 SHALL, while rst_i=1, force state IDLE, bub_cnt=0, both counters 0, PCWrite_o=1, Stall_o=0, NoOp_o=0, MemStall_o=0.
REQ-030 SHALL, on reset asserted mid-LU_STALL, abandon the sequence; the first post-reset cycle is IDLE.

Configuration
REQ-031 SHALL, with macro HAZARD_PERF_CNT_EN defined, increment lu_cnt_o on each cycle with NoOp_o=1 and mem_cnt_o on each cycle with MemStall_o=1, both saturating at all-ones.
REQ-032 SHALL, without HAZARD_PERF_CNT_EN, keep both counter ports present and tied to 0, with no counter flops.

Verification
REQ-033 SHALL cover: LU_CYC=1, EX load rd=5, ID rs2=5 with use=1 -> exactly one cycle of PCWrite_o=0, Stall_o=1, NoOp_o=1.
REQ-034 SHALL cover: EX load rd=0, ID rs1=0 with use=1; or rd=7, rs1=7 with use=0 -> no stall.
REQ-035 SHALL cover: LU_CYC=3, hazard, with the hazard term dropped after 1 cycle -> 3 consecutive bubble cycles, then IDLE.
REQ-036 SHALL cover: LU_CYC=3, mem_stall_i=1 for 4 cycles during the 2nd bubble -> MemStall_o=1 and NoOp_o=0 for 4 cycles, then 2 remaining bubbles.
REQ-037 SHALL cover: flush_i=1 on a hazard cycle -> no stall, IDLE; rst_i pulse mid-LU_STALL -> outputs return to their reset values immediately.
REQ-038 SHALL cover: with HAZARD_PERF_CNT_EN, CNT_W=2, and 5 bubble cycles -> lu_cnt_o saturates at 3.
